// File: rtl/return_stack_ctrl.sv
// Return-address stack sequencer: CALL/RET/RESET over valid/ready, drives a sync-read stack RAM.
// Optional RSTACK_WRAP_EN: CALL on a full stack overwrites the oldest entry instead of faulting.
module return_stack_ctrl #(
  parameter int PC_WIDTH     = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int DEPTH_LOG2   = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_CALL  = 'h1,
  parameter logic [OPCODE_WIDTH-1:0] OP_RET   = 'h2,
  parameter logic [OPCODE_WIDTH-1:0] OP_RESET = 'h3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [PC_WIDTH-1:0]     called_from,
  output logic [PC_WIDTH-1:0]     return_to,
  output logic                    ret_valid,
  output logic                    mem_we,
  output logic [DEPTH_LOG2-1:0]   mem_addr,
  output logic [PC_WIDTH-1:0]     mem_wdata,
  input  logic [PC_WIDTH-1:0]     mem_rdata,
  output logic [DEPTH_LOG2:0]     depth,
  output logic                    empty,
  output logic                    full,
  output logic                    fault,
  output logic [1:0]              fault_code,
  input  logic                    fault_clear
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef RSTACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, FAULT} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] sp_q, sp_d;
  logic [DEPTH_LOG2:0]   depth_q, depth_d;
  logic [PC_WIDTH-1:0]   return_to_q, return_to_d;
  logic                  ret_valid_q, ret_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
  logic [PC_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;
  logic                  full_w, empty_w, accept_w;

  assign full_w   = (depth_q == DEPTH_V);
  assign empty_w  = (depth_q == '0);
  assign accept_w = op_valid && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    depth_d      = depth_q;
    return_to_d  = return_to_q;
    ret_valid_d  = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (opcode == OP_CALL) begin
            if (!full_w || WRAP_EN) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = sp_q;
              mem_wdata_d = called_from + 1'b1;
              state_d     = WRITE;
            end else begin
              fault_d      = 1'b1;
              fault_code_d = 2'b01;
              state_d      = FAULT;
            end
          end else if (opcode == OP_RET) begin
            if (!empty_w) begin
              mem_addr_d = sp_q - 1'b1;
              state_d    = READ;
            end else begin
              fault_d      = 1'b1;
              fault_code_d = 2'b10;
              state_d      = FAULT;
            end
          end else if (opcode == OP_RESET) begin
            sp_d    = '0;
            depth_d = '0;
          end
        end
      end
      WRITE: begin
        // depth only saturates here when a wrapping CALL overwrote the oldest entry
        sp_d    = sp_q + 1'b1;
        depth_d = full_w ? depth_q : depth_q + 1'b1;
        state_d = IDLE;
      end
      READ: begin
        sp_d    = sp_q - 1'b1;
        depth_d = depth_q - 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        return_to_d = mem_rdata;
        ret_valid_d = 1'b1;
        state_d     = IDLE;
      end
      FAULT: begin
        if (fault_clear) begin
          fault_d      = 1'b0;
          fault_code_d = 2'b00;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sp_q         <= '0;
      depth_q      <= '0;
      return_to_q  <= '0;
      ret_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      depth_q      <= depth_d;
      return_to_q  <= return_to_d;
      ret_valid_q  <= ret_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign op_ready   = (state_q == IDLE);
  assign return_to  = return_to_q;
  assign ret_valid  = ret_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign depth      = depth_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
